// File: rtl/dcache_direct_mapped_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_direct_mapped_pkg
//  Description : Shared constants for the direct-mapped data cache: FSM state
//                encodings, line geometry and address-field helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_direct_mapped_pkg;

    // Line geometry: four words per line, so the word offset is two bits.
    localparam int c_LINE_WORDS  = 4;
    localparam int c_OFFSET_BITS = 2;

    // Controller states.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Line-aligned form of a word address (offset bits cleared).
    function automatic logic [15:0] line_base(input logic [15:0] addr);
        line_base = {addr[15:c_OFFSET_BITS], {c_OFFSET_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_data_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_tag_data_array
//  Description : Valid/tag/data storage for the direct-mapped data cache.
//                Combinational lookup port (hit + word), synchronous line
//                fill and word update ports. Only valid bits are reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_tag_data_array
    import dcache_direct_mapped_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = c_LINE_WORDS,
    parameter int TAG_BITS   = 12,
    parameter int IDX_BITS   = $clog2(NUM_LINES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // lookup port
    input  logic [IDX_BITS-1:0]             i_rd_index,
    input  logic [TAG_BITS-1:0]             i_rd_tag,
    input  logic [c_OFFSET_BITS-1:0]        i_rd_offset,
    output logic                            o_rd_hit,
    output logic [WORD_SIZE-1:0]            o_rd_word,
    // line fill port
    input  logic                            i_line_we,
    input  logic [IDX_BITS-1:0]             i_line_index,
    input  logic [TAG_BITS-1:0]             i_line_tag,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] i_line_data,
    // single-word update port
    input  logic                            i_word_we,
    input  logic [IDX_BITS-1:0]             i_word_index,
    input  logic [c_OFFSET_BITS-1:0]        i_word_offset,
    input  logic [WORD_SIZE-1:0]            i_word_data
);

    logic [NUM_LINES-1:0]            r_valid;
    logic [TAG_BITS-1:0]             r_tag  [NUM_LINES];
    logic [LINE_WORDS*WORD_SIZE-1:0] r_data [NUM_LINES];
    logic [LINE_WORDS*WORD_SIZE-1:0] w_line;

    // Valid bits: cleared asynchronously, set only by a completed line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_line_we) begin
            r_valid[i_line_index] <= 1'b1;
        end
    end

    // Tag/data storage: a fill replaces the whole line; a store-hit patches one word.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_line_index]  <= i_line_tag;
            r_data[i_line_index] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_word_index][i_word_offset*WORD_SIZE +: WORD_SIZE] <= i_word_data;
        end
    end

    // Lookup: hit needs a valid line with matching tag; the word is muxed by offset.
    always_comb begin
        w_line    = r_data[i_rd_index];
        o_rd_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
        o_rd_word = w_line[i_rd_offset*WORD_SIZE +: WORD_SIZE];
    end

endmodule
`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_direct_mapped
//  Description : Direct-mapped, write-through, no-write-allocate data cache.
//                Load hits complete with zero stall; load misses fetch a
//                4-word line; stores always go to memory and patch the line
//                only on a hit. Saturating load hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_direct_mapped
    import dcache_direct_mapped_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                            Clk,
    input  logic                            Reset_N,
    input  logic                            c_readM,
    input  logic                            c_writeM,
    input  logic [WORD_SIZE-1:0]            c_address,
    input  logic [WORD_SIZE-1:0]            c_wdata,
    output logic [WORD_SIZE-1:0]            c_rdata,
    output logic                            c_ready,
    output logic                            m_req,
    output logic                            m_we,
    output logic [WORD_SIZE-1:0]            m_address,
    output logic [WORD_SIZE-1:0]            m_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] m_rdata,
    input  logic                            m_ack,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = WORD_SIZE - IDX_BITS - c_OFFSET_BITS;

    logic [1:0]           r_state;
    logic [WORD_SIZE-1:0] r_addr;        // request latched on leaving IDLE
    logic [WORD_SIZE-1:0] w_lookup_addr;
    logic                 w_hit;
    logic [WORD_SIZE-1:0] w_word;
    logic                 w_idle;
    logic                 w_load;        // pure load (a load+store is a store)
    logic                 w_fill_we;
    logic                 w_word_we;

    // In IDLE the lookup follows the CPU; afterwards it follows the latched request.
    always_comb begin
        w_idle        = (r_state == c_ST_IDLE);
        w_lookup_addr = w_idle ? c_address : r_addr;
        w_load        = c_readM && !c_writeM;
        w_fill_we     = (r_state == c_ST_FILL)  && m_ack;
        w_word_we     = (r_state == c_ST_WRITE) && m_ack && w_hit;
    end

    dcache_tag_data_array #(
        .NUM_LINES  (NUM_LINES),
        .WORD_SIZE  (WORD_SIZE),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS),
        .IDX_BITS   (IDX_BITS)
    ) u_array (
        .clk           (Clk),
        .rst_n         (Reset_N),
        .i_rd_index    (w_lookup_addr[IDX_BITS+c_OFFSET_BITS-1:c_OFFSET_BITS]),
        .i_rd_tag      (w_lookup_addr[WORD_SIZE-1:IDX_BITS+c_OFFSET_BITS]),
        .i_rd_offset   (w_lookup_addr[c_OFFSET_BITS-1:0]),
        .o_rd_hit      (w_hit),
        .o_rd_word     (w_word),
        .i_line_we     (w_fill_we),
        .i_line_index  (r_addr[IDX_BITS+c_OFFSET_BITS-1:c_OFFSET_BITS]),
        .i_line_tag    (r_addr[WORD_SIZE-1:IDX_BITS+c_OFFSET_BITS]),
        .i_line_data   (m_rdata),
        .i_word_we     (w_word_we),
        .i_word_index  (r_addr[IDX_BITS+c_OFFSET_BITS-1:c_OFFSET_BITS]),
        .i_word_offset (r_addr[c_OFFSET_BITS-1:0]),
        .i_word_data   (m_wdata)
    );

    // CPU handshake: stall on any store or load miss in IDLE, release in DONE;
    // both outputs are forced low while reset is asserted.
    always_comb begin
        c_ready = 1'b0;
        c_rdata = '0;
        if (Reset_N) begin
            case (r_state)
                c_ST_IDLE: c_ready = !(c_writeM || (c_readM && !w_hit));
                c_ST_DONE: c_ready = 1'b1;
                default:   c_ready = 1'b0;
            endcase
            if (w_idle) begin
                c_rdata = w_word;
            end
        end
    end

    // Controller FSM and registered memory-side request.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state   <= c_ST_IDLE;
            r_addr    <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (c_writeM) begin
                        r_state   <= c_ST_WRITE;
                        r_addr    <= c_address;
                        m_req     <= 1'b1;
                        m_we      <= 1'b1;
                        m_address <= c_address;
                        m_wdata   <= c_wdata;
                    end else if (c_readM && !w_hit) begin
                        r_state   <= c_ST_FILL;
                        r_addr    <= c_address;
                        m_req     <= 1'b1;
                        m_we      <= 1'b0;
                        m_address <= {c_address[WORD_SIZE-1:c_OFFSET_BITS], {c_OFFSET_BITS{1'b0}}};
                    end
                end
                c_ST_FILL: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_WRITE: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Saturating load counters: hits per IDLE hit cycle, misses on entering FILL.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (w_idle && w_load) begin
            if (w_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (!w_hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_direct_mapped
//  Description : Self-checking bench for dcache_direct_mapped. A behavioural
//                model (backing memory array + resident-line table) predicts
//                stalls, load data and counter values for directed and
//                randomized access sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_direct_mapped;

    localparam int NL = 4;

    logic        Clk;
    logic        Reset_N;
    logic        c_readM;
    logic        c_writeM;
    logic [15:0] c_address;
    logic [15:0] c_wdata;
    logic [15:0] c_rdata;
    logic        c_ready;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_address;
    logic [15:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [15:0] mem [int];
    int          line_of [NL];   // resident line number (addr>>2) per index, -1 = empty
    int          hits;
    int          misses;

    dcache_direct_mapped #(
        .NUM_LINES  (NL),
        .WORD_SIZE  (16),
        .LINE_WORDS (4)
    ) dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .c_readM    (c_readM),
        .c_writeM   (c_writeM),
        .c_address  (c_address),
        .c_wdata    (c_wdata),
        .c_rdata    (c_rdata),
        .c_ready    (c_ready),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_address  (m_address),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mem_rd(input int a);
        logic [15:0] v;
        if (mem.exists(a)) begin
            v = mem[a];
        end else begin
            v = 16'(a * 40503) ^ 16'h5A5A;
        end
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) line_of[i] = -1;
        hits   = 0;
        misses = 0;
    endfunction

    // One CPU access, starting and ending at a negative clock edge.
    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input int lat, input string tag);
        int          a;
        int          idx;
        bit          is_store;
        bit          is_load;
        bit          exp_hit;
        int          exp_stall;
        int          stall;
        int          reqc;
        logic [63:0] line;
        a         = int'(addr);
        idx       = (a >> 2) % NL;
        is_store  = wr;
        is_load   = rd && !wr;
        exp_hit   = is_load && (line_of[idx] == (a >> 2));
        exp_stall = (is_store || (is_load && !exp_hit)) ? lat + 2 : 0;

        c_readM   = rd;
        c_writeM  = wr;
        c_address = addr;
        c_wdata   = wd;
        stall     = 0;
        reqc      = 0;
        forever begin
            #1;
            if (c_ready === 1'b1 || stall >= 60) break;
            if (m_req === 1'b1) begin
                reqc++;
                if (reqc == 1) begin
                    check({tag, "_m_we"}, {31'b0, m_we}, {31'b0, is_store});
                    check({tag, "_m_address"}, {16'b0, m_address},
                          is_store ? {16'b0, addr} : {16'b0, addr[15:2], 2'b00});
                    if (is_store) check({tag, "_m_wdata"}, {16'b0, m_wdata}, {16'b0, wd});
                end
                for (int k = 0; k < 4; k++) line[16*k +: 16] = mem_rd(((a >> 2) << 2) + k);
                m_rdata = line;
                if (reqc == lat + 1) m_ack = 1'b1;
            end
            @(posedge Clk);
            @(negedge Clk);
            m_ack = 1'b0;
            stall++;
        end
        check({tag, "_stall"}, stall, exp_stall);
        check({tag, "_m_req_done"}, {31'b0, m_req}, 32'd0);
        if (is_load) check({tag, "_rdata"}, {16'b0, c_rdata}, {16'b0, mem_rd(a)});

        if (is_store) begin
            mem[a] = wd;
        end else if (is_load) begin
            if (!exp_hit) begin
                misses++;
                line_of[idx] = a >> 2;
            end
            hits++;
        end

        @(posedge Clk);
        @(negedge Clk);
        c_readM  = 1'b0;
        c_writeM = 1'b0;
        #1;
        check({tag, "_hit_count"}, {16'b0, hit_count}, hits);
        check({tag, "_miss_count"}, {16'b0, miss_count}, misses);
    endtask

    initial begin
        int          op;
        logic [15:0] ra;
        logic [15:0] rw;

        Reset_N   = 1'b0;
        c_readM   = 1'b0;
        c_writeM  = 1'b0;
        c_address = '0;
        c_wdata   = '0;
        m_rdata   = '0;
        m_ack     = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(negedge Clk);
        #1;
        check("rst_c_ready",   {31'b0, c_ready},   32'd0);
        check("rst_c_rdata",   {16'b0, c_rdata},   32'd0);
        check("rst_m_req",     {31'b0, m_req},     32'd0);
        check("rst_m_we",      {31'b0, m_we},      32'd0);
        check("rst_m_address", {16'b0, m_address}, 32'd0);
        check("rst_m_wdata",   {16'b0, m_wdata},   32'd0);
        check("rst_hits",      {16'b0, hit_count}, 32'd0);
        check("rst_misses",    {16'b0, miss_count}, 32'd0);
        @(negedge Clk);
        Reset_N = 1'b1;
        #1;
        check("idle_ready", {31'b0, c_ready}, 32'd1);
        @(negedge Clk);

        // cold load with a known line
        mem[16'h0010] = 16'hA000;
        mem[16'h0011] = 16'hB001;
        mem[16'h0012] = 16'hC002;
        mem[16'h0013] = 16'hD003;
        access(1, 0, 16'h0013, 16'h0000, 3, "cold");
        access(1, 0, 16'h0010, 16'h0000, 3, "hitA");
        access(1, 0, 16'h0011, 16'h0000, 3, "hitB");
        access(1, 0, 16'h0012, 16'h0000, 3, "hitC");

        // store hit updates the line, load sees it with no stall
        access(0, 1, 16'h0011, 16'h1234, 2, "st_hit");
        access(1, 0, 16'h0011, 16'h0000, 2, "ld_after_st");

        // store miss does not allocate
        access(0, 1, 16'h0040, 16'hBEEF, 1, "st_miss");
        access(1, 0, 16'h0040, 16'h0000, 1, "ld_after_stmiss");

        // conflicting lines on index 0
        access(1, 0, 16'h0010, 16'h0000, 0, "conf_a");
        access(1, 0, 16'h0020, 16'h0000, 0, "conf_b");
        access(1, 0, 16'h0010, 16'h0000, 0, "conf_a2");

        // load+store together behaves as a store
        access(1, 1, 16'h0012, 16'h7777, 1, "both");
        access(1, 0, 16'h0012, 16'h0000, 1, "ld_after_both");

        // randomized mix over a small address window to provoke hits and conflicts
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            ra = 16'($urandom_range(0, 16'h007F));
            rw = 16'($urandom);
            if (op <= 5)      access(1, 0, ra, rw, $urandom_range(0, 4), "rnd_ld");
            else if (op <= 7) access(0, 1, ra, rw, $urandom_range(0, 4), "rnd_st");
            else if (op == 8) access(1, 1, ra, rw, $urandom_range(0, 4), "rnd_both");
            else              access(0, 0, ra, rw, 0, "rnd_idle");
        end

        // reset in the middle of a fill
        access(1, 0, 16'h0104, 16'h0000, 0, "pre_rst");
        c_readM   = 1'b1;
        c_address = 16'h0208;
        @(posedge Clk);
        @(negedge Clk);
        #1;
        check("midfill_req", {31'b0, m_req}, 32'd1);
        Reset_N = 1'b0;
        #1;
        check("midrst_m_req",   {31'b0, m_req},      32'd0);
        check("midrst_ready",   {31'b0, c_ready},    32'd0);
        check("midrst_rdata",   {16'b0, c_rdata},    32'd0);
        check("midrst_hits",    {16'b0, hit_count},  32'd0);
        check("midrst_misses",  {16'b0, miss_count}, 32'd0);
        m_ack = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        m_ack   = 1'b0;
        c_readM = 1'b0;
        Reset_N = 1'b1;
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        #1;
        check("late_ack_req", {31'b0, m_req}, 32'd0);
        access(1, 0, 16'h0208, 16'h0000, 2, "post_rst_ld");
        access(1, 0, 16'h0104, 16'h0000, 1, "post_rst_ld2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU's data-memory port and the backing data memory.
- Converts word accesses (16-bit word address) into 4-word line fills from a multi-cycle memory with a req/ack handshake.
- Exposes a ready signal that the pipeline uses as its MEM-stage stall.
- Exposes hit and miss counters for performance measurement.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, ≥2. IDX_BITS = log2(NUM_LINES).
- WORD_SIZE, 16, data and address width.
- LINE_WORDS, 4, words per line; fixed, giving a 2-bit offset.

Ports:
- Clk  input  1  rising-edge clock
- Reset_N  input  1  asynchronous active-low reset
- c_readM  input  1  CPU load request
- c_writeM  input  1  CPU store request
- c_address  input  16  CPU word address
- c_wdata  input  16  store data
- c_rdata  output  16  load data; valid when c_ready=1 and c_readM=1
- c_ready  output  1  access completes this cycle; 0 = stall the pipeline
- m_req  output  1  memory request
- m_we  output  1  1 = word write, 0 = line read
- m_address  output  16  line-aligned address (offset 00) for reads; word address for writes
- m_wdata  output  16  write data
- m_rdata  input  64  fill line; word k in bits [16k+15:16k]
- m_ack  input  1  one-cycle pulse; request complete
- hit_count  output  16  saturating load-hit count
- miss_count  output  16  saturating load-miss count

Behaviour:
- Address split: offset = addr[1:0]; index = addr[IDX_BITS+1:2]; tag = addr[15:IDX_BITS+2].
- Storage per line: valid bit, tag, 4×16 data.
- Reset (asynchronous): all valid bits 0; state IDLE; m_req=0, m_we=0, m_address=0, m_wdata=0; counters 0.
- Reset outputs: c_ready=0 and c_rdata=0 while reset is asserted.
- IDLE, no request: c_ready=1.
- IDLE, load hit (valid and tag match): c_rdata driven combinationally from the line; c_ready=1 in the same cycle; zero-stall.
- IDLE, load hit counting: hit_count increments once per hit cycle.
- IDLE, load miss:
  - c_ready=0; go to FILL.
  - Next edge: m_req=1, m_we=0, m_address={addr[15:2],2'b00}.
  - miss_count increments once, on the IDLE→FILL transition.
- FILL:
  - Hold m_req and m_address stable until m_ack.
  - On the m_ack edge: write m_rdata into the line, set tag, set valid=1, drop m_req, return to IDLE.
  - The following cycle is a hit: c_ready=1, hit_count increments.
  - Minimum miss penalty = memory latency + 2 cycles.
- IDLE, store (hit or miss):
  - c_ready=0; go to WRITE.
  - Next edge: m_req=1, m_we=1, m_address=c_address, m_wdata=c_wdata.
- WRITE:
  - On m_ack: if the address hits, update that word in the line; on a miss the cache is unchanged (no allocate).
  - Drop m_req; go to DONE.
- DONE: exactly one cycle; c_ready=1 so the pipeline retires the store; then IDLE.
- Same-request rule: the CPU holds c_address, c_wdata and the request stable while c_ready=0. The cache latches the request on leaving IDLE and ignores CPU input changes during FILL and WRITE.
- c_readM and c_writeM both 1: treated as a store; no load is counted.
- m_ack outside FILL or WRITE (e.g. a late ack after reset): ignored.
- Reset during FILL or WRITE: the operation is abandoned, no line is modified, m_req drops immediately.
- Counters saturate at 16'hFFFF; they do not wrap.
- Writes never set valid.
- Index wrap-around: addresses differing only in tag map to the same line and evict it on refill.

Decomposition:
- Shared constants file: state encodings (IDLE, FILL, WRITE, DONE), LINE_WORDS, offset width.
- Place these next to the existing opcode and constant definitions.
- Natural sub-module dcache_tag_data_array: valid/tag/data storage with asynchronous reset of the valid bits only.
  - Combinational read port returning hit and the word.
  - Synchronous line-write and word-write ports.
- The FSM and counters stay in the top module.

Test Plan:
- Cold load 16'h0013, memory latency 3, line {16'hD003,16'hC002,16'hB001,16'hA000} → m_req with m_address=16'h0010; c_ready=0 for 5 cycles; then c_rdata=16'hD003; miss_count=1, hit_count=1.
- Back-to-back loads 0x0010, 0x0011, 0x0012 after the fill → c_ready=1 every cycle, data A000/B001/C002, hit_count=4, no m_req.
- Store 16'h1234 to 0x0011 (hit), then load 0x0011 → m_we=1 with m_address=0x0011; DONE pulse; load returns 16'h1234 with zero stall.
- Store to uncached 0x0040, then load 0x0040 → store does not allocate; load misses, issuing a line read at 0x0040.
- Conflict: load 0x0010, then load 0x0020 (NUM_LINES=4, same index 0) → second is a miss and refills; reload of 0x0010 misses again; miss_count=3.
- Assert Reset_N=0 mid-FILL, then pulse m_ack → m_req=0 immediately, ack ignored, next load to the same address misses, counters 0 before it.
